serv_alu_seq: RTL and testbench
===============================

# serv_alu_seq

Self-sequenced, width-parametrised serial ALU for the SERV core family. It accepts one command per operation and consumes both 32-bit operands as 32/W beats of W bits, LSB chunk first. It streams the arithmetic or boolean result per beat and reports a registered compare result with a done pulse at the end. It sits between the operand buffers and rd writeback; it replaces external counter and compare bookkeeping with an internal beat counter and FSM.

## Interface

- W, default 1: bits per beat. Legal values are 1, 2, 4, 8, 16 and 32; any other value is an elaboration error.
- XLEN, default 32: operand width. Fixed at 32.
- clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high, on clock clk.
- i_start  in  1  command valid. Accepted only in IDLE or FIN.
- i_op  in  3  operation, sampled with i_start:
  - 000 ADD, 001 SUB, 010 SLT, 011 SLTU
  - 100 XOR, 101 EQ, 110 OR, 111 AND
- i_en  in  1  beat enable in RUN. Low means stall; operands are ignored.
- i_rs1  in  W  rs1 chunk for the current beat.
- i_op_b  in  W  op_b chunk for the current beat.
- o_busy  out  1  high in RUN.
- o_cnt  out  log2(32/W) (min 1)  index of the current beat.
- o_rd  out  W  result chunk. Combinational; nonzero only when RUN & i_en.
- o_done  out  1  one-cycle pulse in FIN.
- o_cmp  out  1  compare result. Registered; valid from FIN until the next accepted start.
- o_ovf  out  1  signed overflow. Present only with SERV_ALU_OVF_EN.

## Operation

- Define N = 32/W.
- FSM states: IDLE, RUN, FIN.
  - IDLE: i_start goes to RUN.
  - RUN: each cycle with i_en=1 consumes one beat. The beat with o_cnt==N-1 goes to FIN.
  - FIN: lasts one cycle. i_start goes to RUN (back-to-back); otherwise go to IDLE.
- On start:
  - Latch the op.
  - Clear o_cnt.
  - Initialise carry register cy_r to 1 for SUB/SLT/SLTU, else 0.
  - Set eq_r to 1.
- Per enabled beat:
  - b' = i_op_b ^ {W{sub}}, where sub is 1 for SUB/SLT/SLTU.
  - {cy, sum} = i_rs1 + b' + cy_r, computed W+1 bits wide.
  - Update cy_r with cy.
  - Update eq_r with eq_r & ~|(i_rs1 ^ i_op_b).
- o_rd by op:
  - ADD/SUB: sum.
  - XOR/OR/AND: bitwise result.
  - SLT/SLTU/EQ: zero. The caller writes o_cmp into rd bit 0.
- o_cmp, registered on the last beat:
  - SLT/SLTU: the sign of sx(rs1) - sx(op_b) as a 33-bit result. This equals rs1_sx ^ ~opb_sx ^ cy, where the sign extension _sx applies only for SLT.
  - EQ: final eq_r.
  - Other ops: 0.
- Boundary conditions:
  - i_start in RUN is ignored.
  - i_en low in IDLE/FIN has no effect.
  - A stall on the last beat delays FIN.
  - i_rst mid-RUN abandons the operation and goes to IDLE next cycle. No o_done pulse is produced.
  - With W=32, N=1: RUN lasts one enabled cycle.

## Timing

- Reset values: state IDLE, o_busy 0, o_done 0, o_cmp 0, o_cnt 0, o_ovf 0, cy_r 0, eq_r 1. o_rd is 0 because it is gated.
- i_start accepted at cycle t:
  - RUN covers t+1..t+N when i_en is held high.
  - o_done is high at t+N+1.
  - Each stalled cycle adds one cycle.
- o_rd for a beat is valid in the same cycle as that beat's operands (zero-latency combinational path).
- o_cmp and o_ovf update only in the cycle entering FIN, and hold until the next accepted start.

## Configuration

- Macro: SERV_ALU_OVF_EN.
- Defined:
  - Adds the o_ovf port.
  - Valid in FIN: for ADD/SUB, ovf = (rs1[31] == b'[31]) & (sum[31] != rs1[31]), taken from the last beat. For other ops it is 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure

- Package serv_alu_pkg holds:
  - The op enum serv_alu_op_e (3 bits, encoding above).
  - The FSM state enum.
  - The localparam function nbeats(W).
  - The cnt-width helper.
- Sub-module serv_alu_slice: the combinational W-bit datapath. Inputs are rs1, op_b, sub and carry-in; outputs are sum, carry-out, bool results and zero-detect. The top level holds the FSM, counter, cy_r, eq_r and the output registers.

## Test plan

- **ADD overflow.** W=4: ADD 0x7FFFFFFF + 0x00000001.
  - o_rd beats reassemble to 0x80000000.
  - o_done is high at t+9.
  - o_ovf=1 when enabled.
- **SLT vs SLTU.** W=1: rs1=0xFFFFFFFF, op_b=0x00000001.
  - SLT gives o_cmp=1.
  - SLTU gives o_cmp=0.
  - o_rd is always 0.
- **EQ.** W=8:
  - 0x00001234 vs 0x00001234 gives o_cmp=1.
  - 0x80001234 vs 0x00001234 gives o_cmp=0 (differs only in the last beat).
- **Stall.** W=2 SUB 5-7 with i_en low for 3 cycles at beat 7.
  - Result 0xFFFFFFFE.
  - o_done delayed exactly 3 cycles.
- **Reset mid-RUN.** i_rst at beat 3.
  - o_busy=0 and o_cmp=0 next cycle; no o_done.
  - A following AND 0xF0F0F0F0 & 0xFF00FF00 yields 0xF000F000.
- **Back-to-back.** i_start asserted in the FIN cycle.
  - RUN re-entered the next cycle.
  - The second result is correct and uncorrupted by the first carry.

Source files
------------

// File: rtl/serv_alu_pkg.sv
// Shared types and sizing helpers for the serial SERV ALU (serv_alu_seq).
package serv_alu_pkg;

   localparam int XLEN_C = 32;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_SLT  = 3'b010,
      OP_SLTU = 3'b011,
      OP_XOR  = 3'b100,
      OP_EQ   = 3'b101,
      OP_OR   = 3'b110,
      OP_AND  = 3'b111
   } serv_alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } serv_alu_state_e;

   function automatic int nbeats(input int w);
      return XLEN_C / w;
   endfunction

   // Beat counter width; a single-beat build still carries a 1-bit counter.
   function automatic int cnt_w(input int w);
      return (nbeats(w) > 1) ? $clog2(nbeats(w)) : 1;
   endfunction

   function automatic logic op_is_sub(input serv_alu_op_e op);
      return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
   endfunction

endpackage

// File: rtl/serv_alu_seq_if.sv
// Command/beat interface of serv_alu_seq; o_ovf exists only with SERV_ALU_OVF_EN.
interface serv_alu_seq_if #(parameter int W = 1) ();
   import serv_alu_pkg::*;

   localparam int CW = cnt_w(W);

   logic            i_start;
   serv_alu_op_e    i_op;
   logic            i_en;
   logic [W-1:0]    i_rs1;
   logic [W-1:0]    i_op_b;
   logic            o_busy;
   logic [CW-1:0]   o_cnt;
   logic [W-1:0]    o_rd;
   logic            o_done;
   logic            o_cmp;
`ifdef SERV_ALU_OVF_EN
   logic            o_ovf;

   modport master (output i_start, i_op, i_en, i_rs1, i_op_b,
                   input  o_busy, o_cnt, o_rd, o_done, o_cmp, o_ovf);
   modport slave  (input  i_start, i_op, i_en, i_rs1, i_op_b,
                   output o_busy, o_cnt, o_rd, o_done, o_cmp, o_ovf);
`else
   modport master (output i_start, i_op, i_en, i_rs1, i_op_b,
                   input  o_busy, o_cnt, o_rd, o_done, o_cmp);
   modport slave  (input  i_start, i_op, i_en, i_rs1, i_op_b,
                   output o_busy, o_cnt, o_rd, o_done, o_cmp);
`endif

endinterface

// File: rtl/serv_alu_slice.sv
// Combinational W-bit ALU slice: add/subtract with carry, boolean ops, equality detect.
module serv_alu_slice #(
   parameter int W = 1
) (
   input  logic [W-1:0] i_rs1,
   input  logic [W-1:0] i_op_b,
   input  logic         i_sub,
   input  logic         i_cy,
   output logic [W-1:0] o_sum,
   output logic         o_cy,
   output logic [W-1:0] o_xor,
   output logic [W-1:0] o_or,
   output logic [W-1:0] o_and,
   output logic         o_zero
);

   logic [W-1:0] w_b;
   logic [W:0]   w_add;

   assign w_b   = i_op_b ^ {W{i_sub}};
   assign w_add = {1'b0, i_rs1} + {1'b0, w_b} + {{W{1'b0}}, i_cy};

   assign o_sum  = w_add[W-1:0];
   assign o_cy   = w_add[W];
   assign o_xor  = i_rs1 ^ i_op_b;
   assign o_or   = i_rs1 | i_op_b;
   assign o_and  = i_rs1 & i_op_b;
   assign o_zero = ~|(i_rs1 ^ i_op_b);

endmodule

// File: rtl/serv_alu_seq.sv
// Self-sequenced serial ALU: beat counter, IDLE/RUN/FIN FSM, carry/equality state and
// registered compare result. Optional signed-overflow flag under SERV_ALU_OVF_EN.
module serv_alu_seq
   import serv_alu_pkg::*;
#(
   parameter int W    = 1,
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            i_rst,
   serv_alu_seq_if.slave   bus
);

   localparam int N  = nbeats(W);
   localparam int CW = cnt_w(W);

   generate
      if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32) || XLEN != XLEN_C)
      begin : g_bad_cfg
         $error("serv_alu_seq: W must be 1/2/4/8/16/32 and XLEN must be 32");
      end
   endgenerate

   serv_alu_state_e r_state, w_state_nxt;
   serv_alu_op_e    r_op;
   logic [CW-1:0]   r_cnt;
   logic            r_cy;
   logic            r_eq;
   logic            r_cmp;

   logic            w_accept;
   logic            w_beat;
   logic            w_last;
   logic            w_sub;
   logic [W-1:0]    w_sum;
   logic [W-1:0]    w_xor;
   logic [W-1:0]    w_or;
   logic [W-1:0]    w_and;
   logic            w_cy;
   logic            w_zero;
   logic            w_rs1_sx;
   logic            w_opb_sx;
   logic            w_cmp_nxt;

   assign w_sub = op_is_sub(r_op);

   serv_alu_slice #(.W(W)) u_slice (
      .i_rs1  (bus.i_rs1),
      .i_op_b (bus.i_op_b),
      .i_sub  (w_sub),
      .i_cy   (r_cy),
      .o_sum  (w_sum),
      .o_cy   (w_cy),
      .o_xor  (w_xor),
      .o_or   (w_or),
      .o_and  (w_and),
      .o_zero (w_zero)
   );

   always_ff @(posedge clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_beat      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.i_start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.i_en) begin
               w_beat = 1'b1;
               if (r_cnt == CW'(N - 1)) begin
                  w_last      = 1'b1;
                  w_state_nxt = ST_FIN;
               end
            end
         end
         ST_FIN: begin
            if (bus.i_start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // The op register needs no reset: it is only looked at after an accepted start.
   always_ff @(posedge clk) begin
      if (w_accept) r_op <= bus.i_op;
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_cnt <= '0;
         r_cy  <= 1'b0;
         r_eq  <= 1'b1;
      end else if (w_accept) begin
         r_cnt <= '0;
         r_cy  <= op_is_sub(bus.i_op);
         r_eq  <= 1'b1;
      end else if (w_beat) begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         r_cy  <= w_cy;
         r_eq  <= r_eq & w_zero;
      end
   end

   // Compare sign of the 33-bit difference; SLTU extends both operands with zero.
   always_comb begin
      w_rs1_sx  = 1'b0;
      w_opb_sx  = 1'b0;
      w_cmp_nxt = 1'b0;
      if (r_op == OP_SLT) begin
         w_rs1_sx = bus.i_rs1[W-1];
         w_opb_sx = bus.i_op_b[W-1];
      end
      case (r_op)
         OP_SLT, OP_SLTU: w_cmp_nxt = w_rs1_sx ^ ~w_opb_sx ^ w_cy;
         OP_EQ:           w_cmp_nxt = r_eq & w_zero;
         default:         w_cmp_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_rst)       r_cmp <= 1'b0;
      else if (w_last) r_cmp <= w_cmp_nxt;
   end

   always_comb begin
      bus.o_rd = '0;
      if (r_state == ST_RUN && bus.i_en) begin
         case (r_op)
            OP_ADD, OP_SUB: bus.o_rd = w_sum;
            OP_XOR:         bus.o_rd = w_xor;
            OP_OR:          bus.o_rd = w_or;
            OP_AND:         bus.o_rd = w_and;
            default:        bus.o_rd = '0;
         endcase
      end
   end

   assign bus.o_busy = (r_state == ST_RUN);
   assign bus.o_done = (r_state == ST_FIN);
   assign bus.o_cnt  = r_cnt;
   assign bus.o_cmp  = r_cmp;

`ifdef SERV_ALU_OVF_EN
   logic r_ovf;
   logic w_b_msb;
   logic w_ovf_nxt;

   assign w_b_msb   = bus.i_op_b[W-1] ^ w_sub;
   assign w_ovf_nxt = ((r_op == OP_ADD) || (r_op == OP_SUB)) &
                      (bus.i_rs1[W-1] == w_b_msb) & (w_sum[W-1] != bus.i_rs1[W-1]);

   always_ff @(posedge clk) begin
      if (i_rst)       r_ovf <= 1'b0;
      else if (w_last) r_ovf <= w_ovf_nxt;
   end

   assign bus.o_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serv_alu_seq.sv
// Directed self-checking bench for serv_alu_seq: a W=4 instance for the main sequence
// and a W=32 instance for the single-beat case.
module tb_serv_alu_seq;
   import serv_alu_pkg::*;

   localparam int TW = 4;
   localparam int N  = 32 / TW;

   logic        clk = 1'b0;
   logic        rst;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          edges   = 0;
   logic [31:0] got_rd;

   always #5 clk = ~clk;

   serv_alu_seq_if #(.W(TW)) bus ();
   serv_alu_seq_if #(.W(32)) bus32 ();

   serv_alu_seq #(.W(TW), .XLEN(32)) dut (
      .clk   (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   serv_alu_seq #(.W(32), .XLEN(32)) dut32 (
      .clk   (clk),
      .i_rst (rst),
      .bus   (bus32)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic issue(input serv_alu_op_e op);
      bus.i_start = 1'b1;
      bus.i_op    = op;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      edges       = 0;
   endtask

   // Feed beats [first, first+nb); stall_n idle cycles are inserted before beat stall_at.
   task automatic feed(input logic [31:0] a, input logic [31:0] b,
                       input int first, input int nb, input int stall_at, input int stall_n);
      for (int k = first; k < first + nb; k++) begin
         if (k == stall_at) begin
            for (int s = 0; s < stall_n; s++) begin
               bus.i_en   = 1'b0;
               bus.i_rs1  = '1;
               bus.i_op_b = '1;
               #1;
               chk("stall_rd", 32'(bus.o_rd), 32'h0);
               chk("stall_done", 32'(bus.o_done), 32'h0);
               @(posedge clk); #1;
               edges++;
            end
         end
         bus.i_en   = 1'b1;
         bus.i_rs1  = a[k*TW +: TW];
         bus.i_op_b = b[k*TW +: TW];
         #1;
         got_rd[k*TW +: TW] = bus.o_rd;
         chk("beat_cnt", 32'(bus.o_cnt), 32'(k));
         @(posedge clk); #1;
         edges++;
      end
      bus.i_en = 1'b0;
   endtask

   task automatic run(input serv_alu_op_e op, input logic [31:0] a, input logic [31:0] b);
      issue(op);
      feed(a, b, 0, N, -1, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      bus.i_start = 1'b0;  bus.i_op = OP_ADD;  bus.i_en = 1'b0;
      bus.i_rs1 = '0;      bus.i_op_b = '0;
      bus32.i_start = 1'b0; bus32.i_op = OP_ADD; bus32.i_en = 1'b0;
      bus32.i_rs1 = '0;     bus32.i_op_b = '0;
      got_rd = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state; enable in IDLE must do nothing
      bus.i_en = 1'b1; bus.i_rs1 = 4'hF; bus.i_op_b = 4'h1;
      #1;
      chk("rst_busy", 32'(bus.o_busy), 32'h0);
      chk("rst_done", 32'(bus.o_done), 32'h0);
      chk("rst_cmp",  32'(bus.o_cmp),  32'h0);
      chk("rst_cnt",  32'(bus.o_cnt),  32'h0);
      chk("rst_rd",   32'(bus.o_rd),   32'h0);
`ifdef SERV_ALU_OVF_EN
      chk("rst_ovf",  32'(bus.o_ovf),  32'h0);
`endif
      @(posedge clk); #1;
      chk("idle_en_cnt", 32'(bus.o_cnt), 32'h0);
      chk("idle_en_busy", 32'(bus.o_busy), 32'h0);
      bus.i_en = 1'b0;

      // ADD with signed overflow
      issue(OP_ADD);
      chk("add_busy", 32'(bus.o_busy), 32'h1);
      feed(32'h7FFF_FFFF, 32'h0000_0001, 0, N, -1, 0);
      chk("add_rd",   got_rd, 32'h8000_0000);
      chk("add_lat",  32'(edges), 32'(N));
      chk("add_done", 32'(bus.o_done), 32'h1);
      chk("add_cmp",  32'(bus.o_cmp), 32'h0);
`ifdef SERV_ALU_OVF_EN
      chk("add_ovf",  32'(bus.o_ovf), 32'h1);
`endif
      @(posedge clk); #1;
      chk("add_done_pulse", 32'(bus.o_done), 32'h0);

      // SLTU / SLT on -1 vs 1, then unsigned 5 < 7
      run(OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001);
      chk("sltu_cmp", 32'(bus.o_cmp), 32'h0);
      chk("sltu_rd",  got_rd, 32'h0);
      run(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
      chk("slt_cmp",  32'(bus.o_cmp), 32'h1);
      chk("slt_rd",   got_rd, 32'h0);
      run(OP_SLTU, 32'h0000_0005, 32'h0000_0007);
      chk("sltu_lt_cmp", 32'(bus.o_cmp), 32'h1);

      // EQ, including a difference confined to the last beat
      run(OP_EQ, 32'h0000_1234, 32'h0000_1234);
      chk("eq_same",  32'(bus.o_cmp), 32'h1);
      run(OP_EQ, 32'h8000_1234, 32'h0000_1234);
      chk("eq_last",  32'(bus.o_cmp), 32'h0);
      chk("eq_rd",    got_rd, 32'h0);

      // SUB with a 3-cycle stall before the last beat
      issue(OP_SUB);
      feed(32'h0000_0005, 32'h0000_0007, 0, N, N - 1, 3);
      chk("stall_res",  got_rd, 32'hFFFF_FFFE);
      chk("stall_lat",  32'(edges), 32'(N + 3));
      chk("stall_fin",  32'(bus.o_done), 32'h1);
`ifdef SERV_ALU_OVF_EN
      chk("sub_ovf0",   32'(bus.o_ovf), 32'h0);
`endif
      run(OP_SUB, 32'h8000_0000, 32'h0000_0001);
      chk("sub_min_rd", got_rd, 32'h7FFF_FFFF);
`ifdef SERV_ALU_OVF_EN
      chk("sub_ovf1",   32'(bus.o_ovf), 32'h1);
`endif

      // Boolean ops
      run(OP_XOR, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
      chk("xor_rd", got_rd, 32'hAAAA_AAAA);
      run(OP_OR, 32'h1234_0000, 32'h0000_5678);
      chk("or_rd", got_rd, 32'h1234_5678);

      // Start during RUN is ignored
      issue(OP_ADD);
      bus.i_start = 1'b1; bus.i_op = OP_XOR;
      feed(32'h0000_FFFF, 32'h0000_0001, 0, N / 2, -1, 0);
      bus.i_start = 1'b0;
      feed(32'h0000_FFFF, 32'h0000_0001, N / 2, N / 2, -1, 0);
      chk("ign_start_rd",  got_rd, 32'h0001_0000);
      chk("ign_start_lat", 32'(edges), 32'(N));

      // Reset mid-RUN: set o_cmp first so the clear is visible
      run(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
      chk("pre_rst_cmp", 32'(bus.o_cmp), 32'h1);
      issue(OP_XOR);
      feed(32'h1234_5678, 32'h1111_1111, 0, 3, -1, 0);
      bus.i_en = 1'b1; bus.i_rs1 = 4'h3; bus.i_op_b = 4'h1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; bus.i_en = 1'b0;
      #1;
      chk("midrst_busy", 32'(bus.o_busy), 32'h0);
      chk("midrst_cmp",  32'(bus.o_cmp),  32'h0);
      chk("midrst_done", 32'(bus.o_done), 32'h0);
      chk("midrst_cnt",  32'(bus.o_cnt),  32'h0);
      @(posedge clk); #1;
      chk("midrst_nodone", 32'(bus.o_done), 32'h0);
      run(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
      chk("and_rd",   got_rd, 32'hF000_F000);
      chk("and_done", 32'(bus.o_done), 32'h1);

      // Back-to-back: the second ADD must start with a clean carry
      run(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
      chk("b2b_first", got_rd, 32'h0000_0000);
      chk("b2b_fin",   32'(bus.o_done), 32'h1);
      issue(OP_ADD);
      chk("b2b_busy",  32'(bus.o_busy), 32'h1);
      chk("b2b_cnt",   32'(bus.o_cnt),  32'h0);
      feed(32'h0000_0003, 32'h0000_0004, 0, N, -1, 0);
      chk("b2b_second", got_rd, 32'h0000_0007);
      chk("b2b_done2",  32'(bus.o_done), 32'h1);

      // Single-beat instance: RUN lasts exactly one enabled cycle
      bus32.i_start = 1'b1; bus32.i_op = OP_ADD;
      @(posedge clk); #1;
      bus32.i_start = 1'b0;
      chk("w32_busy", 32'(bus32.o_busy), 32'h1);
      bus32.i_en = 1'b1; bus32.i_rs1 = 32'h1234_5678; bus32.i_op_b = 32'h1111_1111;
      #1;
      chk("w32_rd", bus32.o_rd, 32'h2345_6789);
      @(posedge clk); #1;
      bus32.i_en = 1'b0;
      chk("w32_done", 32'(bus32.o_done), 32'h1);
      chk("w32_idle_busy", 32'(bus32.o_busy), 32'h0);
      bus32.i_start = 1'b1; bus32.i_op = OP_SLTU;
      @(posedge clk); #1;
      bus32.i_start = 1'b0;
      bus32.i_en = 1'b1; bus32.i_rs1 = 32'h0000_0002; bus32.i_op_b = 32'h0000_0003;
      @(posedge clk); #1;
      bus32.i_en = 1'b0;
      chk("w32_sltu_cmp",  32'(bus32.o_cmp),  32'h1);
      chk("w32_sltu_done", 32'(bus32.o_done), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
